lsu_memory_responder: RTL and testbench

- Responder end of the LSU memory-op interface: accepts the single memory operation the LSU control fires each cycle (load or store, address, data, LDQ tag) and answers it after a fixed pipeline latency.
- Contains a word-addressed data array, an in-order response pipeline with backpressure, and fault detection for misaligned and out-of-range accesses.
- Sits between the LSU and data memory; load responses return to the load queue by LDQ index, and store responses retire the STQ head.

---
 rtl/lsu_memory_responder.sv | 98 +++++++++
 tb/tb_lsu_memory_responder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_memory_responder.sv
// Memory responder for the LSU: word-addressed data array behind a fixed-latency,
// in-order response pipeline with backpressure and misalign/range fault detection.
module lsu_memory_responder #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned LDQ_SIZE  = 32,
    parameter int unsigned MEM_DEPTH = 1024,
    parameter int unsigned LATENCY   = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        fire_memory_op,
    input  logic                        memory_op_type,
    input  logic [XLEN-1:0]             memory_address,
    input  logic [XLEN-1:0]             memory_data,
    input  logic [$clog2(LDQ_SIZE)-1:0] memory_ldq_index,
    output logic                        memory_ready,
    output logic                        response_valid,
    output logic                        response_type,
    output logic [XLEN-1:0]             response_data,
    output logic [$clog2(LDQ_SIZE)-1:0] response_ldq_index,
    output logic                        response_fault,
    input  logic                        response_ready
);

    localparam int unsigned TAG_W = $clog2(LDQ_SIZE);
    localparam int unsigned AW    = $clog2(MEM_DEPTH);

    typedef struct packed {
        logic             valid;
        logic             op_type;
        logic [XLEN-1:0]  data;
        logic [TAG_W-1:0] idx;
        logic             fault;
    } stage_t;

    stage_t          stage_q [LATENCY];
    stage_t          stage_d [LATENCY];
    stage_t          entry;
    logic [XLEN-1:0] mem_q [MEM_DEPTH];
    logic            stall;
    logic            accept;
    logic            fault_c;
    logic [AW-1:0]   widx;

    assign stall        = stage_q[LATENCY-1].valid && !response_ready;
    assign memory_ready = !stall;
    assign accept       = fire_memory_op && !stall;
    assign widx         = memory_address[AW+1:2];

    // Any set bit above the word index means the byte address is beyond the array.
    assign fault_c = (memory_address[1:0] != 2'b00) || (|memory_address[XLEN-1:AW+2]);

    // Bubbles carry all-zero payloads so idle outputs read as zero.
    always_comb begin
        entry = '0;
        if (accept) begin
            entry.valid   = 1'b1;
            entry.op_type = memory_op_type;
            entry.idx     = memory_ldq_index;
            entry.fault   = fault_c;
            entry.data    = (!memory_op_type && !fault_c) ? mem_q[widx] : '0;
        end
    end

    always_comb begin
        stage_d = stage_q;
        if (!stall) begin
            stage_d[0] = entry;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    // Array contents survive reset; only successful stores write.
    always_ff @(posedge clk) begin
        if (accept && memory_op_type && !fault_c) begin
            mem_q[widx] <= memory_data;
        end
    end

    assign response_valid     = stage_q[LATENCY-1].valid;
    assign response_type      = stage_q[LATENCY-1].op_type;
    assign response_data      = stage_q[LATENCY-1].data;
    assign response_ldq_index = stage_q[LATENCY-1].idx;
    assign response_fault     = stage_q[LATENCY-1].fault;

endmodule

// File: tb/tb_lsu_memory_responder.sv
// Scoreboard bench for lsu_memory_responder: driver pushes model expectations,
// a negedge monitor pops and compares on every response handshake.
module tb_lsu_memory_responder;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned LDQ_SIZE  = 32;
    localparam int unsigned TAG_W     = 5;
    localparam int unsigned MEM_DEPTH = 1024;
    localparam int unsigned LAT       = 2;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic             fire, op_type, mready, rvalid, rtype, rfault, rready;
    logic [XLEN-1:0]  addr, wdata, rdata;
    logic [TAG_W-1:0] tag, ridx;

    logic             f1, t1, mready1, rv1, rtype1, rfault1, rr1;
    logic [XLEN-1:0]  a1, d1, rdata1;
    logic [TAG_W-1:0] tg1, ridx1;

    typedef struct {
        logic             op_type;
        logic [XLEN-1:0]  data;
        logic [TAG_W-1:0] idx;
        logic             fault;
        bit               lat_chk;
        int               exp_cyc;
    } exp_t;

    exp_t            sb_q[$];
    exp_t            mon_e;
    logic [XLEN-1:0] mdl_mem [MEM_DEPTH];
    int              n_chk = 0;
    int              n_pass = 0;
    int              cyc = 0;
    bit              lat_mode = 1'b0;

    lsu_memory_responder #(.XLEN(XLEN), .LDQ_SIZE(LDQ_SIZE), .MEM_DEPTH(MEM_DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .reset_n(reset_n), .fire_memory_op(fire), .memory_op_type(op_type),
        .memory_address(addr), .memory_data(wdata), .memory_ldq_index(tag),
        .memory_ready(mready), .response_valid(rvalid), .response_type(rtype),
        .response_data(rdata), .response_ldq_index(ridx), .response_fault(rfault),
        .response_ready(rready)
    );

    lsu_memory_responder #(.XLEN(XLEN), .LDQ_SIZE(LDQ_SIZE), .MEM_DEPTH(MEM_DEPTH), .LATENCY(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .fire_memory_op(f1), .memory_op_type(t1),
        .memory_address(a1), .memory_data(d1), .memory_ldq_index(tg1),
        .memory_ready(mready1), .response_valid(rv1), .response_type(rtype1),
        .response_data(rdata1), .response_ldq_index(ridx1), .response_fault(rfault1),
        .response_ready(rr1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference behaviour: byte address -> fault / word / expected payload.
    function automatic exp_t model_op(input logic t, input logic [XLEN-1:0] a, input logic [TAG_W-1:0] tg);
        exp_t e;
        longint unsigned ai = 64'(a);
        e.op_type = t;
        e.idx     = tg;
        e.fault   = (ai % 4 != 0) || (ai >= 64'(MEM_DEPTH) * 4);
        e.data    = (!t && !e.fault) ? mdl_mem[int'((ai / 4) % 64'(MEM_DEPTH))] : '0;
        e.lat_chk = 1'b0;
        e.exp_cyc = 0;
        return e;
    endfunction

    task automatic drive(input bit f, input bit t, input logic [XLEN-1:0] a, input logic [XLEN-1:0] d,
                         input logic [TAG_W-1:0] tg, input bit rr);
        exp_t e;
        bit   stall_exp;
        @(posedge clk);
        #2;
        fire = f; op_type = t; addr = a; wdata = d; tag = tg; rready = rr;
        #1;
        stall_exp = rvalid && !rr;
        check("memory_ready", 64'(mready), 64'(!stall_exp));
        if (f && !stall_exp) begin
            e = model_op(t, a, tg);
            e.lat_chk = lat_mode;
            e.exp_cyc = cyc + int'(LAT);
            sb_q.push_back(e);
            if (t && !e.fault) mdl_mem[int'((64'(a) / 4) % 64'(MEM_DEPTH))] = d;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb_q.size() != 0; i++) drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
        drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
        check("drain_empty", 64'(sb_q.size()), 64'd0);
    endtask

    // Monitor: compare on every handshake, idle outputs must be zero.
    always @(negedge clk) begin
        if (reset_n) begin
            if (rvalid) begin
                if (rready) begin
                    if (sb_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL unexpected_response: got response tag %0d, expected none", ridx);
                    end else begin
                        mon_e = sb_q.pop_front();
                        check("resp_type", 64'(rtype), 64'(mon_e.op_type));
                        check("resp_fault", 64'(rfault), 64'(mon_e.fault));
                        check("resp_data", 64'(rdata), 64'(mon_e.data));
                        if (!mon_e.op_type) check("resp_idx", 64'(ridx), 64'(mon_e.idx));
                        if (mon_e.lat_chk) check("resp_latency", 64'(cyc), 64'(mon_e.exp_cyc));
                    end
                end
            end else begin
                check("idle_outputs", 64'({rtype, rdata, ridx, rfault}), 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [XLEN-1:0] a;
        int              w;
        bit              got;
        fire = 0; op_type = 0; addr = '0; wdata = '0; tag = '0; rready = 1'b1;
        f1 = 0; t1 = 0; a1 = '0; d1 = '0; tg1 = '0; rr1 = 1'b1;
        #1 reset_n = 1'b0;
        #3;
        check("reset_valid", 64'(rvalid), 64'd0);
        check("reset_ready", 64'(mready), 64'd1);
        check("reset_outputs", 64'({rtype, rdata, ridx, rfault}), 64'd0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;

        // Single-stage instance: response visible the cycle after the fire cycle.
        @(posedge clk); #2;
        f1 = 1; t1 = 1; a1 = 32'h80; d1 = 32'hCAFE_F00D; tg1 = '0;
        @(posedge clk); #1;
        check("l1_store_valid", 64'(rv1), 64'd1);
        check("l1_store_type", 64'(rtype1), 64'd1);
        check("l1_store_data", 64'(rdata1), 64'd0);
        #1 t1 = 0; tg1 = 5'd3;
        @(posedge clk); #1;
        f1 = 0;
        check("l1_load_valid", 64'(rv1), 64'd1);
        check("l1_load_type", 64'(rtype1), 64'd0);
        check("l1_load_data", 64'(rdata1), 64'hCAFE_F00D);
        check("l1_load_idx", 64'(ridx1), 64'd3);
        @(posedge clk); #1;
        check("l1_idle", 64'(rv1), 64'd0);

        // Prefill window words 0..15 (0x11..0x44 in the first four).
        lat_mode = 1'b1;
        for (int i = 0; i < 16; i++)
            drive(1'b1, 1'b1, 32'(i * 4), (i < 4) ? 32'(8'h11 * (i + 1)) : $urandom, '0, 1'b1);
        drive(1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, '0, 1'b1);
        drive(1'b1, 1'b0, 32'h40, '0, 5'd5, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 32'(i * 4), '0, 5'(i + 1), 1'b1);
        drain();

        // Backpressure: held response, dropped store fire, ordered drain.
        lat_mode = 1'b0;
        drive(1'b1, 1'b0, 32'h8, '0, 5'd9, 1'b0);
        drive(1'b1, 1'b0, 32'hC, '0, 5'd10, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
            got = rvalid;
        end
        check("bp_resp_seen", 64'(got), 64'd1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 32'h0, 32'hBAD0_BAD0, '0, 1'b0);
            check("bp_held_valid", 64'(rvalid), 64'd1);
            check("bp_held_data", 64'(rdata), 64'h33);
            check("bp_held_idx", 64'(ridx), 64'd9);
        end
        drain();
        lat_mode = 1'b1;
        drive(1'b1, 1'b0, 32'h0, '0, 5'd11, 1'b1);
        drain();

        // Faults: misaligned load, out-of-range store, then wrapped word untouched.
        drive(1'b1, 1'b0, 32'h42, '0, 5'd7, 1'b1);
        drive(1'b1, 1'b1, 32'(MEM_DEPTH * 4), 32'h5555_AAAA, '0, 1'b1);
        drive(1'b1, 1'b0, 32'h0, '0, 5'd12, 1'b1);
        drain();

        // Reset with a load in flight: it must vanish, array persists.
        drive(1'b1, 1'b0, 32'h40, '0, 5'd13, 1'b1);
        @(posedge clk); #2;
        reset_n = 1'b0; fire = 1'b0;
        sb_q.delete();
        #1;
        check("midrst_valid", 64'(rvalid), 64'd0);
        check("midrst_ready", 64'(mready), 64'd1);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
        check("postrst_valid", 64'(rvalid), 64'd0);
        drive(1'b1, 1'b0, 32'h40, '0, 5'd14, 1'b1);
        drain();

        // Randomised mix inside the prefilled window plus fault addresses.
        lat_mode = 1'b0;
        for (int i = 0; i < 400; i++) begin
            w = int'($urandom_range(0, 16));
            case ($urandom_range(0, 7))
                0:       a = 32'(w * 4 + int'($urandom_range(1, 3)));
                1:       a = 32'(MEM_DEPTH * 4 + w * 4);
                default: a = 32'(w * 4);
            endcase
            drive(($urandom % 4) != 0, 1'($urandom), a, $urandom, 5'($urandom), ($urandom % 4) != 0);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
